// File: rtl/router_pkt_pkg.sv
// Shared router packet definitions: entry field offsets and the drain FSM
// state encoding. Also imported by the write-side packet builder.
package router_pkt_pkg;

    // Byte offsets of the header fields within a FIFO entry.
    localparam int unsigned FIELD_SRC  = 0;
    localparam int unsigned FIELD_DST  = 1;
    localparam int unsigned FIELD_SIZE = 2;

    // Header bytes ahead of the payload, and trailing crc bytes.
    localparam int unsigned HDR_LEN = 3;
    localparam int unsigned CRC_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_DROP = 3'd2,
        ST_POP  = 3'd3,
        ST_GAP  = 3'd4
    } pkt_state_e;

endpackage : router_pkt_pkg

// File: rtl/packet_tx_if.sv
// Byte-stream output channel of the packet drain engine.
//   out_valid / out_ready : handshake, transfer when both high at clk edge
//   out_data              : byte
//   out_sop / out_eop     : first byte (source_id) / last byte (crc) markers
// master = the packet_tx side, slave = the downstream consumer.
interface packet_tx_if #(
    parameter int unsigned UWIDTH = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [UWIDTH-1:0] out_data;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output out_valid,
        output out_data,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface : packet_tx_if

// File: rtl/packet_tx.sv
// Read-side drain engine for the router packet FIFO. Waits for a stored
// entry, walks its bytes through the FIFO random-access read port, streams
// them on a valid/ready byte channel with sop/eop markers, then pops the
// entry with a single rinc pulse. Entries with an out-of-range size field
// are dropped and flagged on err_size.
// Ports:
//   clk, rst   : FIFO read-domain clock, asynchronous active-low reset
//   rempty     : FIFO empty flag
//   rdata      : head-entry byte at raddr_in (combinational in the FIFO)
//   raddr_in   : byte index within the head entry
//   rinc       : one-cycle pop pulse
//   tx         : output byte stream (packet_tx_if.master)
//   err_size   : one-cycle pulse when an entry is dropped
//   busy       : engine is not idle
module packet_tx
    import router_pkt_pkg::*;
#(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned UWIDTH    = 8,
    parameter int unsigned PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rempty,
    input  logic [UWIDTH-1:0]    rdata,
    output logic [PTR_IN_SZ-1:0] raddr_in,
    output logic                 rinc,
    packet_tx_if.master          tx,
    output logic                 err_size,
    output logic                 busy
);

    // One extra bit so size + 4 never wraps for legal sizes.
    localparam int unsigned LEN_W    = PTR_IN_SZ + 1;
    localparam int unsigned OVERHEAD = HDR_LEN + CRC_LEN;
    localparam int unsigned MAX_SIZE = WIDTH - OVERHEAD;

    pkt_state_e           state_q, state_d;
    logic [PTR_IN_SZ-1:0] idx_q,   idx_d;
    logic [LEN_W-1:0]     len_q,   len_d;
    logic                 last_c;

    // State, byte index and packet length registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        raddr_in     = '0;
        rinc         = 1'b0;
        err_size     = 1'b0;
        tx.out_valid = 1'b0;
        tx.out_sop   = 1'b0;
        tx.out_eop   = 1'b0;
        tx.out_data  = rdata;
        busy         = (state_q != ST_IDLE);
        last_c       = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

        unique case (state_q)
            ST_IDLE: begin
                // Park the read port on the size byte so it can be judged
                // the same cycle the entry becomes visible.
                raddr_in = PTR_IN_SZ'(FIELD_SIZE);
                if (!rempty) begin
                    len_d = LEN_W'(rdata) + LEN_W'(OVERHEAD);
                    if (rdata > UWIDTH'(MAX_SIZE)) begin
                        state_d = ST_DROP;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                // idx only moves on a handshake, so a stall holds the byte.
                raddr_in     = idx_q;
                tx.out_valid = 1'b1;
                tx.out_sop   = (idx_q == PTR_IN_SZ'(FIELD_SRC));
                tx.out_eop   = last_c;
                if (tx.out_ready) begin
                    if (last_c) begin
                        state_d = ST_POP;
                    end else begin
                        idx_d = idx_q + PTR_IN_SZ'(1);
                    end
                end
            end
            ST_DROP: begin
                err_size = 1'b1;
                rinc     = 1'b1;
                state_d  = ST_GAP;
            end
            ST_POP: begin
                rinc    = 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                // Let the FIFO's rempty and read pointer settle after a pop.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : packet_tx

// File: tb/tb_packet_tx.sv
// Scoreboard bench for packet_tx: a behavioural FIFO feeds entries, the
// stimulus pushes expected beats and checks, a monitor pops and compares.
module tb_packet_tx;
    import router_pkt_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rempty;
    logic [7:0] rdata;
    logic [3:0] raddr_in;
    logic       rinc;
    logic       err_size;
    logic       busy;

    packet_tx_if #(.UWIDTH(8)) tx_if ();

    packet_tx #(
        .WIDTH    (11),
        .UWIDTH   (8),
        .PTR_IN_SZ(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rempty  (rempty),
        .rdata   (rdata),
        .raddr_in(raddr_in),
        .rinc    (rinc),
        .tx      (tx_if),
        .err_size(err_size),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Behavioural packet FIFO: head entry readable at raddr_in.
    logic [7:0] mem [16][16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr = 4'd0;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr][raddr_in];

    always @(posedge clk) begin
        if (rinc === 1'b1) rd_ptr <= rd_ptr + 4'd1;
    end

    // Scoreboard queues.
    beat_t exp_q[$];
    chk_t  chk_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int rinc_cnt = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int last_eop_cyc = -100;
    int cur_max = 0;
    int last_max = 0;
    beat_t got_b;
    beat_t exp_b;
    chk_t  c;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_vec++;
            if (c.act != c.exp) begin
                n_miss++;
                $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
            end
        end
        if (rst !== 1'b1) begin
            n_vec++;
            if ({tx_if.out_valid, rinc, busy, err_size, tx_if.out_sop, tx_if.out_eop} !== 6'b0
                || raddr_in !== 4'd2) begin
                n_miss++;
                $display("FAIL in_reset: valid=%b rinc=%b busy=%b err=%b sop=%b eop=%b raddr=%0d expected all 0, raddr 2",
                         tx_if.out_valid, rinc, busy, err_size, tx_if.out_sop, tx_if.out_eop, raddr_in);
            end
        end else begin
            if (tx_if.out_valid) begin
                valid_cnt++;
                if (tx_if.out_sop) cur_max = int'(raddr_in);
                else if (int'(raddr_in) > cur_max) cur_max = int'(raddr_in);
            end
            if (tx_if.out_valid && tx_if.out_ready) begin
                got_b = {tx_if.out_sop, tx_if.out_eop, tx_if.out_data};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL beat: got sop=%b eop=%b data=%0d expected no beat",
                             got_b.sop, got_b.eop, got_b.data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        n_miss++;
                        $display("FAIL beat: got sop=%b eop=%b data=%0d expected sop=%b eop=%b data=%0d",
                                 got_b.sop, got_b.eop, got_b.data, exp_b.sop, exp_b.eop, exp_b.data);
                    end
                end
                if (tx_if.out_eop) begin
                    last_eop_cyc = cyc;
                    last_max     = cur_max;
                end
            end
            if (rinc) begin
                rinc_cnt++;
                if (err_size) begin
                    err_cnt++;
                end else begin
                    n_vec++;
                    if (cyc - last_eop_cyc != 1) begin
                        n_miss++;
                        $display("FAIL rinc_after_eop: got %0d cycles expected 1", cyc - last_eop_cyc);
                    end
                end
            end else if (err_size) begin
                n_vec++;
                n_miss++;
                $display("FAIL err_without_rinc: got rinc=0 expected 1");
            end
        end
    end

    task automatic expect_eq(input string name, input int act, input int exp);
        chk_t r;
        r.name = name;
        r.act  = act;
        r.exp  = exp;
        chk_q.push_back(r);
    endtask

    task automatic load(input byte_q_t b);
        for (int i = 0; i < b.size(); i++) mem[wr_ptr][i] = b[i];
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic push_exp(input byte_q_t b, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.sop  = (i == 0);
            e.eop  = (i == b.size() - 1);
            e.data = b[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic start();
        @(posedge clk);
        #1;
    endtask

    // Runs until the FIFO is empty and the engine idle; reports cycles spent
    // and the cycle of the first out_valid relative to the first IDLE cycle.
    task automatic wait_idle(input int max_cyc, output int cycles, output int first_valid);
        int cnt;
        cnt = 0;
        first_valid = -1;
        while (cnt < max_cyc) begin
            @(negedge clk);
            cnt++;
            if (tx_if.out_valid && first_valid < 0) first_valid = cnt - 1;
            if (cnt > 1 && !busy && rempty) break;
        end
        cycles = cnt - 1;
        expect_eq("idle_reached", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        byte_q_t p;
        int r0, e0, v0, cycles, fv;

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
        wr_ptr          = 4'd0;
        tx_if.out_ready = 1'b0;
        rst             = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle with an empty FIFO.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_eq("idle_valid", int'(tx_if.out_valid), 0);
            expect_eq("idle_rinc",  int'(rinc), 0);
            expect_eq("idle_raddr", int'(raddr_in), 2);
            expect_eq("idle_busy",  int'(busy), 0);
        end

        // Single 7-byte packet, ready held high.
        start();
        tx_if.out_ready = 1'b1;
        r0 = rinc_cnt; e0 = err_cnt;
        p = {8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        load(p);
        push_exp(p, p.size());
        wait_idle(40, cycles, fv);
        expect_eq("pkt7_cycles",  cycles, 10);
        expect_eq("pkt7_latency", fv, 1);
        expect_eq("pkt7_rinc",    rinc_cnt - r0, 1);
        expect_eq("pkt7_err",     err_cnt - e0, 0);

        // Four back-to-back entries, ready toggling 1010...
        start();
        r0 = rinc_cnt; e0 = err_cnt;
        for (int s = 3; s <= 6; s++) begin
            p = {8'(s * 16 + 1), 8'(s * 16 + 2), 8'(s)};
            for (int d = 0; d < s; d++) p.push_back(8'(s * 16 + 3 + d));
            p.push_back(8'(8'hE0 + s));
            load(p);
            push_exp(p, p.size());
        end
        tx_if.out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k > 1 && rempty && !busy) break;
            @(posedge clk);
            #1 tx_if.out_ready = ~tx_if.out_ready;
        end
        expect_eq("b2b_idle",    int'(busy), 0);
        expect_eq("b2b_empty",   int'(rempty), 1);
        expect_eq("b2b_rinc",    rinc_cnt - r0, 4);
        expect_eq("b2b_err",     err_cnt - e0, 0);
        expect_eq("b2b_drained", exp_q.size(), 0);

        // size = 0: four bytes, eop on the crc.
        start();
        tx_if.out_ready = 1'b1;
        r0 = rinc_cnt;
        p = {8'd1, 8'd2, 8'd0, 8'h55};
        load(p);
        push_exp(p, p.size());
        wait_idle(40, cycles, fv);
        expect_eq("size0_cycles", cycles, 7);
        expect_eq("size0_rinc",   rinc_cnt - r0, 1);

        // size = 7: eleven bytes, raddr_in reaches 10.
        start();
        r0 = rinc_cnt;
        p = {8'd3, 8'd4, 8'd7, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'hAA};
        load(p);
        push_exp(p, p.size());
        wait_idle(40, cycles, fv);
        expect_eq("size7_cycles", cycles, 14);
        expect_eq("size7_raddr",  last_max, 10);
        expect_eq("size7_rinc",   rinc_cnt - r0, 1);

        // size = 8: dropped, flagged and popped, nothing sent.
        start();
        r0 = rinc_cnt; e0 = err_cnt; v0 = valid_cnt;
        p = {8'd5, 8'd6, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'hBB};
        load(p);
        wait_idle(40, cycles, fv);
        expect_eq("size8_cycles", cycles, 3);
        expect_eq("size8_err",    err_cnt - e0, 1);
        expect_eq("size8_rinc",   rinc_cnt - r0, 1);
        expect_eq("size8_valid",  valid_cnt - v0, 0);

        // Reset after three accepted bytes, then full resend.
        start();
        r0 = rinc_cnt;
        p = {8'd7, 8'd8, 8'd2, 8'd10, 8'd11, 8'd12};
        load(p);
        push_exp(p, 3);
        push_exp(p, p.size());
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_valid", int'(tx_if.out_valid), 0);
        expect_eq("rst_busy",  int'(busy), 0);
        expect_eq("rst_raddr", int'(raddr_in), 2);
        repeat (2) @(posedge clk);
        expect_eq("rst_no_rinc", rinc_cnt - r0, 0);
        expect_eq("rst_no_pop",  int'(rempty), 0);
        #1 rst = 1'b1;
        wait_idle(40, cycles, fv);
        expect_eq("resend_cycles",  cycles, 9);
        expect_eq("resend_rinc",    rinc_cnt - r0, 1);
        expect_eq("resend_drained", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_packet_tx
